pc_predict_unit: RTL and testbench

PC_PREDICT_UNIT -- requirements
Module: pc_predict_unit

---
 rtl/pc_predict_unit.sv | 112 +++++++++++
 tb/tb_pc_predict_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_predict_unit.sv
// Fetch-stage PC selection and next-PC prediction for a Y86 pipeline.
// Branches and calls predict taken; returns predict from a circular return-address stack.
module pc_predict_unit #(
    parameter int ADDR_W = 64,
    parameter int RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             f_valid,
    input  logic [3:0]                       f_icode,
    input  logic [ADDR_W-1:0]                f_valC,
    input  logic [ADDR_W-1:0]                f_valP,
    input  logic                             stall,
    input  logic                             m_mispredict,
    input  logic [ADDR_W-1:0]                m_valA,
    input  logic                             w_ret,
    input  logic [ADDR_W-1:0]                w_valM,
    output logic [ADDR_W-1:0]                f_pc,
    output logic [ADDR_W-1:0]                pred_pc,
    output logic                             ras_hit,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [3:0] ICODE_JXX  = 4'h7;
    localparam logic [3:0] ICODE_CALL = 4'h8;
    localparam logic [3:0] ICODE_RET  = 4'h9;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;
    logic [CNT_W-1:0]  ras_cnt;
    logic              ras_nonempty;
    logic              ras_full;
    logic [ADDR_W-1:0] ras_top;
    logic              is_call;
    logic              is_ret;
    logic              advance;
    logic              do_push;
    logic              do_pop;
    logic [ADDR_W-1:0] next_pred;

    // ras_ptr names the next slot to write; the top entry sits just below it.
    always_comb begin
        ptr_inc = (ras_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr + PTR_W'(1);
        ptr_dec = (ras_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr - PTR_W'(1);
    end

    assign ras_top      = ras_mem[ptr_dec];
    assign ras_nonempty = (ras_cnt != '0);
    assign ras_full     = (ras_cnt == CNT_W'(RAS_DEPTH));

    assign is_call = f_valid && (f_icode == ICODE_CALL);
    assign is_ret  = f_valid && (f_icode == ICODE_RET);

    // Late-stage corrections must redirect fetch even while the front end stalls.
    assign advance = !stall || w_ret || m_mispredict;
    assign do_push = advance && is_call;
    assign do_pop  = advance && is_ret && ras_nonempty;

    always_comb begin
        f_pc = pred_pc;
        if (w_ret)
            f_pc = w_valM;
        else if (m_mispredict)
            f_pc = m_valA;
    end

    always_comb begin
        next_pred = f_valP;
        if ((f_icode == ICODE_JXX) || (f_icode == ICODE_CALL))
            next_pred = f_valC;
        else if ((f_icode == ICODE_RET) && ras_nonempty)
            next_pred = ras_top;
    end

    assign ras_hit   = is_ret && ras_nonempty;
    assign ras_count = ras_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_pc <= RESET_PC;
        end else if (advance) begin
            pred_pc <= f_valid ? next_pred : f_pc;
        end
    end

    // A push into a full stack overwrites the oldest entry and leaves the count saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (do_push) begin
            ras_ptr <= ptr_inc;
            if (!ras_full)
                ras_cnt <= ras_cnt + CNT_W'(1);
        end else if (do_pop) begin
            ras_ptr <= ptr_dec;
            ras_cnt <= ras_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push)
            ras_mem[ras_ptr] <= f_valP;
    end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Scoreboard bench for pc_predict_unit: directed scenarios plus random traffic
// checked against a queue-based return-stack model.
module tb_pc_predict_unit;

    localparam int AW = 64;
    localparam int D  = 4;

    logic          clk;
    logic          rst;
    logic          f_valid;
    logic [3:0]    f_icode;
    logic [AW-1:0] f_valC;
    logic [AW-1:0] f_valP;
    logic          stall;
    logic          m_mispredict;
    logic [AW-1:0] m_valA;
    logic          w_ret;
    logic [AW-1:0] w_valM;
    logic [AW-1:0] f_pc;
    logic [AW-1:0] pred_pc;
    logic          ras_hit;
    logic [2:0]    ras_count;

    pc_predict_unit #(.ADDR_W(AW), .RAS_DEPTH(D), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_icode(f_icode),
        .f_valC(f_valC), .f_valP(f_valP), .stall(stall),
        .m_mispredict(m_mispredict), .m_valA(m_valA), .w_ret(w_ret),
        .w_valM(w_valM), .f_pc(f_pc), .pred_pc(pred_pc), .ras_hit(ras_hit),
        .ras_count(ras_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] fpc;
        logic          hit;
        logic [AW-1:0] pred;
        int            cnt;
    } exp_t;

    exp_t          sbq[$];
    logic [AW-1:0] mdl_pred;
    logic [AW-1:0] mdl_ras[$];
    int            checks = 0;
    int            failures = 0;

    // Drive one fetch cycle, record what the outputs must show before the edge,
    // then advance the reference model past the edge.
    task automatic step(input logic v, input logic [3:0] ic, input logic [AW-1:0] c,
                        input logic [AW-1:0] p, input logic st, input logic mis,
                        input logic [AW-1:0] a, input logic wr, input logic [AW-1:0] m);
        exp_t e;
        logic [AW-1:0] nxt;
        @(negedge clk);
        f_valid = v; f_icode = ic; f_valC = c; f_valP = p; stall = st;
        m_mispredict = mis; m_valA = a; w_ret = wr; w_valM = m;
        e.fpc  = wr ? m : (mis ? a : mdl_pred);
        e.hit  = v && (ic == 4'd9) && (mdl_ras.size() > 0);
        e.pred = mdl_pred;
        e.cnt  = mdl_ras.size();
        sbq.push_back(e);
        if (!st || wr || mis) begin
            if (v) begin
                if (ic == 4'd7 || ic == 4'd8)
                    nxt = c;
                else if (ic == 4'd9 && mdl_ras.size() > 0)
                    nxt = mdl_ras[$];
                else
                    nxt = p;
                if (ic == 4'd8) begin
                    mdl_ras.push_back(p);
                    if (mdl_ras.size() > D) void'(mdl_ras.pop_front());
                end else if (ic == 4'd9 && mdl_ras.size() > 0) begin
                    void'(mdl_ras.pop_back());
                end
                mdl_pred = nxt;
            end else begin
                mdl_pred = e.fpc;
            end
        end
    endtask

    task automatic idle_step();
        step(1'b0, 4'd0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    // Raise rst away from any clock edge and confirm it acts without one.
    task automatic apply_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (pred_pc !== '0) begin
            failures++;
            $display("FAIL reset_pred_pc: got %0h expected 0", pred_pc);
        end
        checks++;
        if (ras_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_ras_count: got %0d expected 0", ras_count);
        end
        mdl_pred = '0;
        mdl_ras.delete();
        idle_step();
        #3;
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (f_pc !== e.fpc) begin
                    failures++;
                    $display("FAIL f_pc @%0t: got %0h expected %0h", $time, f_pc, e.fpc);
                end
                checks++;
                if (ras_hit !== e.hit) begin
                    failures++;
                    $display("FAIL ras_hit @%0t: got %0b expected %0b", $time, ras_hit, e.hit);
                end
                checks++;
                if (pred_pc !== e.pred) begin
                    failures++;
                    $display("FAIL pred_pc @%0t: got %0h expected %0h", $time, pred_pc, e.pred);
                end
                checks++;
                if (int'(ras_count) !== e.cnt) begin
                    failures++;
                    $display("FAIL ras_count @%0t: got %0d expected %0d", $time, ras_count, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        int budget;
        f_valid = 1'b0; f_icode = '0; f_valC = '0; f_valP = '0; stall = 1'b0;
        m_mispredict = 1'b0; m_valA = '0; w_ret = 1'b0; w_valM = '0;
        apply_reset();

        // plain instruction falls through
        step(1'b1, 4'd6, 64'd0, 64'd5, 1'b0, 1'b0, '0, 1'b0, '0);
        // jXX predicted taken, then corrected from memory stage
        step(1'b1, 4'd7, 64'd13, 64'd10, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 4'd6, 64'd0, 64'd12, 1'b0, 1'b1, 64'd10, 1'b0, '0);
        step(1'b1, 4'd1, 64'd0, 64'd13, 1'b0, 1'b0, '0, 1'b0, '0);
        // call then ret through the stack
        step(1'b1, 4'd8, 64'd40, 64'd20, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 4'd9, 64'd0, 64'd41, 1'b0, 1'b0, '0, 1'b0, '0);
        idle_step();
        // overflow: five calls, five rets
        for (int i = 0; i < 5; i++)
            step(1'b1, 4'd8, 64'd200 + 64'(i), 64'd100 + 64'(i), 1'b0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 4'd9, 64'd0, 64'd77, 1'b0, 1'b0, '0, 1'b0, '0);
        idle_step();
        // stall holds; writeback ret overrides stall
        step(1'b1, 4'd8, 64'd60, 64'd30, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 4'd7, 64'd55, 64'd61, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b1, 4'd7, 64'd55, 64'd61, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b1, 4'd6, 64'd0, 64'd6, 1'b1, 1'b0, '0, 1'b1, 64'd4);
        step(1'b1, 4'd6, 64'd0, 64'd9, 1'b0, 1'b1, 64'd70, 1'b1, 64'd80);
        // reset in the middle of a sequence
        step(1'b1, 4'd8, 64'd90, 64'd33, 1'b0, 1'b0, '0, 1'b0, '0);
        #3;
        apply_reset();

        for (int n = 0; n < 600; n++) begin
            logic [3:0] ic;
            int sel;
            sel = $urandom_range(0, 9);
            ic = (sel < 3) ? 4'd8 : (sel < 6) ? 4'd9 : (sel < 8) ? 4'd7 : 4'($urandom_range(0, 11));
            step($urandom_range(0, 99) < 85, ic,
                 {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 10, {$urandom, $urandom},
                 $urandom_range(0, 99) < 10, {$urandom, $urandom});
            if ($urandom_range(0, 199) == 0) begin
                #3;
                apply_reset();
            end
        end
        idle_step();

        budget = 20;
        while (sbq.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        #5;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
